// File: rtl/bitonic_cmp_pkg.sv
// bitonic_cmp_pkg: shared state encoding, width helpers and substage count for the bitonic sequencer.
package bitonic_cmp_pkg;
    typedef enum logic [1:0] {LOAD, SORT, UNLOAD} state_t;
    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction
    function automatic int num_substages(input int n);
        return $clog2(n) * ($clog2(n) + 1) / 2;
    endfunction
endpackage

// File: rtl/bitonic_pair_gen.sv
// bitonic_pair_gen: walks the (k,j,pair) schedule of a bitonic sort, one pair per cycle,
// inserting a stall after each substage so its writebacks land before the next substage reads.
module bitonic_pair_gen
    import bitonic_cmp_pkg::*;
#(
    parameter int N = 8,
    parameter int CMP_LAT = 1,
    localparam int PW = idx_w(N),
    localparam int KW = cnt_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    input  logic          asc,
    output logic          issue_valid,
    output logic [PW-1:0] i,
    output logic [PW-1:0] l,
    output logic          dir,
    output logic          substage_last,
    output logic          sort_done
);
    logic [KW-1:0] k;
    logic [PW-1:0] j, m, pe;
    logic [PW-2:0] p;
    logic [2:0]    st;
    logic          last_sub;
    // pair index p becomes i by inserting a zero at bit position log2(j)
    always_comb begin
        m = j - PW'(1);
        pe = {1'b0, p};
        i = ((pe & ~m) << 1) | (pe & m);
        l = i | j;
        dir = ((({1'b0, i} & k) == '0) == asc);
        issue_valid = adv && st == 3'd0;
        substage_last = issue_valid && &p;
        last_sub = k[KW-1] && j == PW'(1);
        sort_done = adv && st == 3'd1 && last_sub;
    end
    always_ff @(posedge clk) begin
        if (rst || !adv) begin
            k <= KW'(2);
            j <= PW'(1);
            p <= '0;
            st <= '0;
        end else if (st != 3'd0) begin
            st <= st - 3'd1;
            if (st == 3'd1) begin
                k <= (j == PW'(1)) ? k << 1 : k;
                j <= (j == PW'(1)) ? k[PW-1:0] : j >> 1;
            end
        end else begin
            p <= p + 1'b1;
            st <= &p ? 3'(CMP_LAT) : 3'd0;
        end
    end
endmodule

// File: rtl/bitonic_cmp_sequencer.sv
// bitonic_cmp_sequencer: loads N words, bitonic-sorts them through one external compare-exchange unit, streams them out.
// Optional sort-length counter output sort_cycles under BITONIC_CMP_SEQUENCER_PERF_EN.
module bitonic_cmp_sequencer
    import bitonic_cmp_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 8,
    parameter int CMP_LAT = 1,
    localparam int PW = idx_w(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ascending,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic           busy,
    output logic           cmp_dir,
    output logic [2*W-1:0] cmp_in,
    input  logic [2*W-1:0] cmp_out
`ifdef BITONIC_CMP_SEQUENCER_PERF_EN
    ,
    output logic [15:0]    sort_cycles
`endif
);
    localparam logic [PW-1:0] LAST = PW'(N - 1);
    localparam logic [PW-1:0] LAST2 = PW'(N - 2);
    state_t        state;
    logic [W-1:0]  mem [N];
    logic [PW-1:0] wr_ptr, rd_ptr, gi, gl, wb_i, wb_l;
    logic [PW-1:0] ti [CMP_LAT+1];
    logic [PW-1:0] tl [CMP_LAT+1];
    logic          tv [CMP_LAT+1];
    logic [W-1:0]  a_i, a_l;
    logic          asc_q, issue, gdir, done, sub_last_unused, wb_v, ld;
    bitonic_pair_gen #(.N(N), .CMP_LAT(CMP_LAT)) u_gen (
        .clk           (clk),
        .rst           (rst),
        .adv           (state == SORT),
        .asc           (asc_q),
        .issue_valid   (issue),
        .i             (gi),
        .l             (gl),
        .dir           (gdir),
        .substage_last (sub_last_unused),
        .sort_done     (done)
    );
    // the first read of a substage shares its edge with the previous substage's final writeback, so forward it
    always_comb begin
        wb_v = tv[CMP_LAT];
        wb_i = ti[CMP_LAT];
        wb_l = tl[CMP_LAT];
        ld = in_valid && in_ready;
        a_i = (wb_v && gi == wb_i) ? cmp_out[W-1:0] : (wb_v && gi == wb_l) ? cmp_out[2*W-1:W] : mem[gi];
        a_l = (wb_v && gl == wb_i) ? cmp_out[W-1:0] : (wb_v && gl == wb_l) ? cmp_out[2*W-1:W] : mem[gl];
        out_data = mem[rd_ptr];
    end
    always_ff @(posedge clk) begin
        if (ld) mem[wr_ptr] <= in_data;
        if (wb_v) begin
            mem[wb_i] <= cmp_out[W-1:0];
            mem[wb_l] <= cmp_out[2*W-1:W];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            busy <= 1'b0;
            cmp_dir <= 1'b0;
            cmp_in <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            asc_q <= 1'b0;
            for (int s = 0; s <= CMP_LAT; s++) begin
                tv[s] <= 1'b0;
                ti[s] <= '0;
                tl[s] <= '0;
            end
        end else begin
            tv[0] <= issue;
            ti[0] <= gi;
            tl[0] <= gl;
            for (int s = 1; s <= CMP_LAT; s++) begin
                tv[s] <= tv[s-1];
                ti[s] <= ti[s-1];
                tl[s] <= tl[s-1];
            end
            if (issue) begin
                cmp_in <= {a_l, a_i};
                cmp_dir <= gdir;
            end
            case (state)
                LOAD: if (ld) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (wr_ptr == '0) asc_q <= ascending;
                    if (wr_ptr == LAST) begin
                        in_ready <= 1'b0;
                        busy <= 1'b1;
                        state <= SORT;
                    end
                end
                SORT: if (done) begin
                    state <= UNLOAD;
                    out_valid <= 1'b1;
                    out_last <= 1'b0;
                end
                UNLOAD: if (out_ready) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    out_last <= rd_ptr == LAST2;
                    if (rd_ptr == LAST) begin
                        state <= LOAD;
                        out_valid <= 1'b0;
                        out_last <= 1'b0;
                        busy <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
`ifdef BITONIC_CMP_SEQUENCER_PERF_EN
    logic [15:0] cyc, cyc_nxt;
    assign cyc_nxt = &cyc ? cyc : cyc + 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc <= '0;
            sort_cycles <= '0;
        end else if (state == SORT) begin
            cyc <= done ? '0 : cyc_nxt;
            if (done) sort_cycles <= cyc_nxt;
        end
    end
`endif
endmodule

// File: tb/tb_bitonic_cmp_sequencer.sv
// tb_bitonic_cmp_sequencer: directed frames against two sequencers (comparator latency 1 and 3).
module tb_bitonic_cmp_sequencer;
    localparam int W = 16;
    localparam int N = 8;
    logic clk = 1'b0, rst = 1'b1, ascending = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic in_ready, out_valid, out_last, busy, cmp_dir;
    logic in_ready3, out_valid3, out_last3, busy3, cmp_dir3;
    logic [W-1:0] out_data, out_data3;
    logic [2*W-1:0] cmp_in, cmp_out, cmp_in3, cmp_out3;
    logic [2*W-1:0] q1 = '0;
    logic [2*W-1:0] q3 [3] = '{default: '0};
    logic [W-1:0] fr [N];
    logic [W-1:0] ex [N];
    logic [W-1:0] got1 [$];
    logic [W-1:0] got3 [$];
    int total = 0, bad = 0;
    int nl1, nl3, li1, li3, sc1, sc3;
    logic st1 = 1'b0, pl1;
    logic [W-1:0] pd1;
`ifdef BITONIC_CMP_SEQUENCER_PERF_EN
    logic [15:0] perf1, perf3;
`endif
    always #5 clk = ~clk;
    bitonic_cmp_sequencer #(.W(W), .N(N), .CMP_LAT(1)) dut (
        .clk(clk), .rst(rst), .ascending(ascending), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .cmp_dir(cmp_dir), .cmp_in(cmp_in), .cmp_out(cmp_out)
`ifdef BITONIC_CMP_SEQUENCER_PERF_EN
        , .sort_cycles(perf1)
`endif
    );
    bitonic_cmp_sequencer #(.W(W), .N(N), .CMP_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .ascending(ascending), .in_valid(in_valid), .in_ready(in_ready3),
        .in_data(in_data), .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
        .out_last(out_last3), .busy(busy3), .cmp_dir(cmp_dir3), .cmp_in(cmp_in3), .cmp_out(cmp_out3)
`ifdef BITONIC_CMP_SEQUENCER_PERF_EN
        , .sort_cycles(perf3)
`endif
    );
    function automatic logic [2*W-1:0] cx(input logic [2*W-1:0] v, input logic d);
        logic [W-1:0] mn, mx;
        mn = (v[W-1:0] < v[2*W-1:W]) ? v[W-1:0] : v[2*W-1:W];
        mx = (v[W-1:0] < v[2*W-1:W]) ? v[2*W-1:W] : v[W-1:0];
        return d ? {mx, mn} : {mn, mx};
    endfunction
    always @(posedge clk) begin
        q1 <= cx(cmp_in, cmp_dir);
        q3[0] <= cx(cmp_in3, cmp_dir3);
        q3[1] <= q3[0];
        q3[2] <= q3[1];
    end
    assign cmp_out = q1;
    assign cmp_out3 = q3[2];
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rst) st1 = 1'b0;
        else begin
            if (st1) begin
                check("hold_data", 32'(out_data), 32'(pd1));
                check("hold_last", 32'(out_last), 32'(pl1));
            end
            if (out_valid && out_ready) begin
                got1.push_back(out_data);
                if (out_last) begin nl1++; li1 = got1.size() - 1; end
            end
            if (out_valid3 && out_ready) begin
                got3.push_back(out_data3);
                if (out_last3) begin nl3++; li3 = got3.size() - 1; end
            end
            if (busy && !out_valid) sc1++;
            if (busy3 && !out_valid3) sc3++;
            st1 = out_valid && !out_ready;
            pd1 = out_data;
            pl1 = out_last;
        end
    end
    task automatic load_frame(input logic asc0, input string tag);
        int cyc = 0;
        while (!(in_ready && in_ready3) && cyc < 100) begin @(posedge clk); #1; cyc++; end
        check({tag, "_ready_wait"}, 32'(cyc < 100), 32'd1);
        for (int b = 0; b < N; b++) begin
            ascending = (b == 0) ? asc0 : !asc0;
            in_valid = 1'b1;
            in_data = fr[b];
            if (b == N - 1) check({tag, "_ready_last_beat"}, 32'({in_ready, in_ready3}), 32'd3);
            @(posedge clk); #1;
        end
        in_data = 16'hDEAD;
        check({tag, "_ready_after_load"}, 32'({in_ready, in_ready3}), 32'd0);
    endtask
    task automatic run_frame(input logic asc0, input bit bp, input string tag);
        int cyc = 0;
        got1.delete(); got3.delete();
        nl1 = 0; nl3 = 0; li1 = -1; li3 = -1; sc1 = 0; sc3 = 0;
        load_frame(asc0, tag);
        repeat (5) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        while (!(got1.size() == N && got3.size() == N && in_ready && in_ready3) && cyc < 3000) begin
            out_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        check({tag, "_timeout"}, 32'(cyc < 3000), 32'd1);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_lat1_word%0d", tag, i), (i < got1.size()) ? 32'(got1[i]) : 32'hFFFF_FFFF, 32'(ex[i]));
            check($sformatf("%s_lat3_word%0d", tag, i), (i < got3.size()) ? 32'(got3[i]) : 32'hFFFF_FFFF, 32'(ex[i]));
        end
        check({tag, "_last_count"}, 32'(nl1 * 16 + nl3), 32'h11);
        check({tag, "_last_pos1"}, 32'(li1), 32'd7);
        check({tag, "_last_pos3"}, 32'(li3), 32'd7);
        check({tag, "_sort_cycles1"}, 32'(sc1), 32'd30);
        check({tag, "_sort_cycles3"}, 32'(sc3), 32'd42);
`ifdef BITONIC_CMP_SEQUENCER_PERF_EN
        check({tag, "_perf1"}, 32'(perf1), 32'd30);
        check({tag, "_perf3"}, 32'(perf3), 32'd42);
`endif
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'({in_ready, in_ready3}), 32'd3);
        check("rst_out_valid", 32'({out_valid, out_valid3}), 32'd0);
        check("rst_out_last", 32'({out_last, out_last3}), 32'd0);
        check("rst_busy", 32'({busy, busy3}), 32'd0);
        check("rst_cmp_dir", 32'({cmp_dir, cmp_dir3}), 32'd0);
        check("rst_cmp_in", cmp_in | cmp_in3, 32'd0);
`ifdef BITONIC_CMP_SEQUENCER_PERF_EN
        check("rst_perf", 32'(perf1 | perf3), 32'd0);
`endif
        rst = 1'b0;
        fr = '{16'd7, 16'd3, 16'd9, 16'd1, 16'd8, 16'd2, 16'd6, 16'd4};
        ex = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd6, 16'd7, 16'd8, 16'd9};
        run_frame(1'b1, 1'b0, "asc");
        ex = '{16'd9, 16'd8, 16'd7, 16'd6, 16'd4, 16'd3, 16'd2, 16'd1};
        run_frame(1'b0, 1'b0, "desc");
        fr = '{16'hFFFF, 16'h0, 16'hFFFF, 16'h5, 16'h0, 16'h5, 16'h5, 16'hFFFF};
        ex = '{16'h0, 16'h0, 16'h5, 16'h5, 16'h5, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        run_frame(1'b1, 1'b0, "dups");
        fr = '{16'd7, 16'd3, 16'd9, 16'd1, 16'd8, 16'd2, 16'd6, 16'd4};
        ex = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd6, 16'd7, 16'd8, 16'd9};
        run_frame(1'b1, 1'b1, "bp");
        fr = '{16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5};
        load_frame(1'b1, "abort");
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        check("abort_busy_mid_sort", 32'({busy, out_valid}), 32'h2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", 32'({in_ready, in_ready3}), 32'd3);
        check("abort_busy", 32'({busy, busy3}), 32'd0);
        check("abort_out_valid", 32'({out_valid, out_valid3}), 32'd0);
        check("abort_cmp_in", cmp_in | cmp_in3, 32'd0);
        fr = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        ex = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        run_frame(1'b1, 1'b0, "fresh");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
